writeback_regfile: RTL
======================

// Module: writeback_regfile
// PURPOSE
// - Writeback stage of the 3-stage RV32 CPU; sits directly downstream of the execute stage and its control unit.
// - Latches the control outputs (regwrite, regsel, gpio_we) together with rd, ALU result, immU and the CSR write data.
// - Selects writeback data and writes the 32x32 register file.
// - Drives the HEX GPIO register and counts retired instructions.
// - Provides combinational read ports, with WB->decode bypass, to the fetch/decode stage.
// PARAMETERS
// XLEN    32  datapath width
// NREGS   32  number of architectural registers (x0 hardwired to 0)
// PORTS
// clk            in   1     system clock, all state on rising edge
// rst_n          in   1     asynchronous active-low reset
// ex_valid       in   1     EX holds a real instruction (0 = bubble)
// ex_regwrite    in   1     control: write rd
// ex_regsel      in   2     control: 00 switches, 01 lui, 10 ALU, 11 reserved
// ex_gpio_we     in   1     control: csrrw HEX, load gpio_out
// ex_rd          in   5     destination register
// ex_alu_result  in   XLEN  ALU output
// ex_immU        in   20    U-type immediate
// ex_csr_wdata   in   XLEN  rs1 value for csrrw
// gpio_in        in   XLEN  board switches, asynchronous to clk
// rs1_addr       in   5     decode read port 1 address
// rs2_addr       in   5     decode read port 2 address
// rs1_data       out  XLEN  read port 1 data (bypassed)
// rs2_data       out  XLEN  read port 2 data (bypassed)
// gpio_out       out  XLEN  HEX display register
// instret        out  32    retired-instruction count
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - all WB pipeline fields, all registers x1..x31, gpio_out, instret and both synchronizer flops clear to 0.
//   - Outputs are 0 within the reset assertion, with no clock needed.
//   - Reset mid-instruction discards the instruction; no partial write.
// - Switch sync: gpio_in passes through a 2-flop synchronizer (sw_s1 -> sw_s2).
//   - sw_s2 is the switch value, 2-cycle latency.
// - WB register, edge N: wb_* <= ex_*.
//   - If ex_valid=0, wb_regwrite and wb_gpio_we are loaded as 0 (bubble).
//   - wb_valid <= ex_valid.
// - wb_wdata (combinational, cycle N..N+1):
//   - regsel 00 -> sw_s2
//   - regsel 01 -> {immU,12'h000}
//   - regsel 10 -> alu_result
//   - regsel 11 -> 0
// - Commit, edge N+1:
//   - regfile[wb_rd] <= wb_wdata if wb_regwrite && wb_rd!=0.
//   - gpio_out <= wb_csr_wdata if wb_gpio_we.
//   - instret <= instret+1 if wb_valid; wraps 0xFFFFFFFF -> 0.
//   - Total latency from EX to architectural state: 2 edges.
// - Read ports (combinational):
//   - addr==0 -> 0 always, even when a bypass matches.
//   - else if wb_regwrite && wb_rd==addr -> wb_wdata (bypass).
//   - else regfile[addr].
//   - Both ports are independent; same address on both ports gives identical data.
// - Writes to x0 are dropped: no state change; instret still increments if valid.
// - csrrw HEX with regwrite=1 updates both gpio_out and rd in the same edge.
// - Back-to-back writes to the same rd: later instruction wins; bypass always reflects the newest WB content.
// TESTING
// - Reset: drive rst_n=0 mid-run with nonzero state.
//   -> rs1_data, rs2_data, gpio_out, instret = 0 immediately, with no clock edge.
// - ALU writeback: valid, regwrite=1, regsel=10, rd=5, alu=0xDEADBEEF, rs1_addr=5.
//   -> rs1_data=0xDEADBEEF one cycle after the EX edge (bypass) and after commit.
// - lui: regsel=01, immU=0x12345, rd=7.
//   -> x7=0x12345000.
//   - Same op with rd=0 -> rs*_addr=0 reads 0, instret still increments.
// - GPIO: gpio_in=0x000000A5, then csrrw SW regsel=00 rd=3 issued 3+ cycles later.
//   -> x3=0xA5.
//   - csrrw HEX gpio_we=1 csr_wdata=0x1F -> gpio_out=0x1F after commit.
// - Bubble: ex_valid=0 with regwrite=1, gpio_we=1.
//   -> no regfile or gpio_out change, instret unchanged.
// - Wrap: force instret=0xFFFFFFFF, retire one instruction -> instret=0x00000000.

Source files
------------

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - RV32 writeback stage: WB latch, 32x32 register file, HEX GPIO, instret
//
// Purpose:
//   Latches the execute-stage control and data fields, selects the writeback
//   value, commits it to the register file one edge later, drives the HEX
//   display register and counts retired instructions. Two combinational read
//   ports with WB->decode bypass serve the fetch/decode stage.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_ex_valid                EX holds a real instruction (0 = bubble)
//   i_ex_regwrite             write rd
//   i_ex_regsel[1:0]          00 switches, 01 lui, 10 ALU, 11 reserved (0)
//   i_ex_gpio_we              csrrw HEX, load gpio_out
//   i_ex_rd[4:0]              destination register
//   i_ex_alu_result[XLEN]     ALU output
//   i_ex_imm_u[19:0]          U-type immediate
//   i_ex_csr_wdata[XLEN]      rs1 value for csrrw
//   i_gpio_in[XLEN]           board switches, asynchronous to i_clk
//   i_rs1_addr, i_rs2_addr    decode read addresses
//   o_rs1_data, o_rs2_data    bypassed read data
//   o_gpio_out[XLEN]          HEX display register
//   o_instret[31:0]           retired-instruction count

module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ex_valid,
    input  logic            i_ex_regwrite,
    input  logic [1:0]      i_ex_regsel,
    input  logic            i_ex_gpio_we,
    input  logic [4:0]      i_ex_rd,
    input  logic [XLEN-1:0] i_ex_alu_result,
    input  logic [19:0]     i_ex_imm_u,
    input  logic [XLEN-1:0] i_ex_csr_wdata,
    input  logic [XLEN-1:0] i_gpio_in,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_gpio_out,
    output logic [31:0]     o_instret
);

    logic [XLEN-1:0] r_sw_s1;
    logic [XLEN-1:0] r_sw_s2;

    logic            r_wb_valid;
    logic            r_wb_regwrite;
    logic [1:0]      r_wb_regsel;
    logic            r_wb_gpio_we;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_alu_result;
    logic [19:0]     r_wb_imm_u;
    logic [XLEN-1:0] r_wb_csr_wdata;

    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] r_gpio_out;
    logic [31:0]     r_instret;

    logic [XLEN-1:0] w_wb_wdata;
    logic            w_wb_commit;

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= i_gpio_in;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // WB latch. A bubble keeps its fields but can never write state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid      <= 1'b0;
            r_wb_regwrite   <= 1'b0;
            r_wb_regsel     <= 2'b00;
            r_wb_gpio_we    <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_alu_result <= '0;
            r_wb_imm_u      <= '0;
            r_wb_csr_wdata  <= '0;
        end else begin
            r_wb_valid      <= i_ex_valid;
            r_wb_regwrite   <= i_ex_valid & i_ex_regwrite;
            r_wb_regsel     <= i_ex_regsel;
            r_wb_gpio_we    <= i_ex_valid & i_ex_gpio_we;
            r_wb_rd         <= i_ex_rd;
            r_wb_alu_result <= i_ex_alu_result;
            r_wb_imm_u      <= i_ex_imm_u;
            r_wb_csr_wdata  <= i_ex_csr_wdata;
        end
    end

    always_comb begin
        w_wb_wdata = '0;
        case (r_wb_regsel)
            2'b00:   w_wb_wdata = r_sw_s2;
            2'b01:   w_wb_wdata = XLEN'({r_wb_imm_u, 12'h000});
            2'b10:   w_wb_wdata = r_wb_alu_result;
            default: w_wb_wdata = '0;
        endcase
    end

    assign w_wb_commit = r_wb_regwrite && (r_wb_rd != 5'd0);

    // Register file; entry 0 is held at zero and never read out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_commit) begin
            r_regs[r_wb_rd] <= w_wb_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gpio_out <= '0;
            r_instret  <= '0;
        end else begin
            if (r_wb_gpio_we) begin
                r_gpio_out <= r_wb_csr_wdata;
            end
            if (r_wb_valid) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // x0 wins over the bypass so a write aimed at x0 is never visible.
    always_comb begin
        o_rs1_data = '0;
        if (i_rs1_addr == 5'd0) begin
            o_rs1_data = '0;
        end else if (r_wb_regwrite && (r_wb_rd == i_rs1_addr)) begin
            o_rs1_data = w_wb_wdata;
        end else begin
            o_rs1_data = r_regs[i_rs1_addr];
        end
    end

    always_comb begin
        o_rs2_data = '0;
        if (i_rs2_addr == 5'd0) begin
            o_rs2_data = '0;
        end else if (r_wb_regwrite && (r_wb_rd == i_rs2_addr)) begin
            o_rs2_data = w_wb_wdata;
        end else begin
            o_rs2_data = r_regs[i_rs2_addr];
        end
    end

    assign o_gpio_out = r_gpio_out;
    assign o_instret  = r_instret;

endmodule
